// File: rtl/vec_mem_seq_pkg.sv
// Shared types for the vector memory sequencer: FSM states, bank ids,
// default widths. No ports. Optional macro VEC_MEM_SEQUENCER_PERF_EN (top).
package vec_mem_seq_pkg;

    localparam int ARQ_DEF    = 32;
    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        BANK1 = 2'd1,
        BANK2 = 2'd2,
        BANK3 = 2'd3
    } bank_e;

    // Bank 1 wins when both read enables are decoded.
    function automatic bank_e sel_rd_bank(input logic r1);
        return r1 ? BANK1 : BANK2;
    endfunction

    // Bank 2 wins when both write enables are decoded.
    function automatic bank_e sel_wr_bank(input logic w2);
        return w2 ? BANK2 : BANK3;
    endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Element counter k with last-element flag and base+k address adders.
// Ports: clk, rst, i_clr/i_inc (k control), i_base_i/i_base_j/i_len,
//        o_rd_addr/o_wr_addr (modulo 2^ADDR_W), o_last (k+1 >= N).
module vec_addr_gen
    import vec_mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_base_i,
    input  logic [ADDR_W-1:0] i_base_j,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_last
);

    logic [LEN_W-1:0]  r_k;
    logic [LEN_W:0]    w_k_nxt;
    logic [ADDR_W-1:0] w_k_a;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_k <= '0;
        end else if (i_inc) begin
            r_k <= r_k + LEN_W'(1);
        end
    end

    // Extra bit keeps k+1 from wrapping when N is the maximum length.
    assign w_k_nxt   = {1'b0, r_k} + (LEN_W+1)'(1);
    assign o_last    = (w_k_nxt >= {1'b0, i_len});
    assign w_k_a     = ADDR_W'(r_k);
    assign o_rd_addr = i_base_i + w_k_a;
    assign o_wr_addr = i_base_j + w_k_a;

endmodule

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer: expands one vector op into N read->ALU->write steps.
// Ports: clk/rst, ctrl_valid/ctrl_ready handshake, decoded bundle
//   (vec_alu_op, r_mem_1/2, w_mem_2/3, base_i/j, vec_len), bank read data,
//   ALU operand/result, bank enables, rd/wr addr, wr_data, stall, done.
// Macro VEC_MEM_SEQUENCER_PERF_EN adds perf_elems (saturating write count).
module vec_mem_sequencer
    import vec_mem_seq_pkg::*;
#(
    parameter int ARQ    = ARQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    input  logic              vec_alu_op,
    input  logic              r_mem_1,
    input  logic              r_mem_2,
    input  logic              w_mem_2,
    input  logic              w_mem_3,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] base_j,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic [ARQ-1:0]    rd_data_1,
    input  logic [ARQ-1:0]    rd_data_2,
    output logic              alu_op_q,
    output logic [ARQ-1:0]    alu_operand,
    input  logic [ARQ-1:0]    alu_result,
    output logic              mem1_re,
    output logic              mem2_re,
    output logic              mem2_we,
    output logic              mem3_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ARQ-1:0]    wr_data,
    output logic              stall,
    output logic              done
`ifdef VEC_MEM_SEQUENCER_PERF_EN
    ,
    output logic [31:0]       perf_elems
`endif
);

    seq_state_e        r_state;
    seq_state_e        w_nxt;
    logic              r_op;
    bank_e             r_rd_bank;
    bank_e             r_wr_bank;
    logic [ADDR_W-1:0] r_base_i;
    logic [ADDR_W-1:0] r_base_j;
    logic [LEN_W-1:0]  r_len;

    logic              w_start;
    logic              w_clr;
    logic              w_inc;
    logic              w_last;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    // Bundles without both a read and a write bank are scalar ops: dropped.
    assign w_start = (r_state == IDLE) && ctrl_valid
                   && (r_mem_1 || r_mem_2)
                   && (w_mem_2 || w_mem_3);

    assign alu_op_q = r_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= 1'b0;
            r_rd_bank <= BANK1;
            r_wr_bank <= BANK2;
            r_base_i  <= '0;
            r_base_j  <= '0;
            r_len     <= '0;
        end else if (w_start) begin
            r_op      <= vec_alu_op;
            r_rd_bank <= sel_rd_bank(r_mem_1);
            r_wr_bank <= sel_wr_bank(w_mem_2);
            r_base_i  <= base_i;
            r_base_j  <= base_j;
            r_len     <= vec_len;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        ctrl_ready  = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        mem1_re     = 1'b0;
        mem2_re     = 1'b0;
        mem2_we     = 1'b0;
        mem3_we     = 1'b0;
        rd_addr     = '0;
        wr_addr     = '0;
        wr_data     = '0;
        alu_operand = '0;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                ctrl_ready = 1'b1;
                if (w_start) begin
                    w_clr = 1'b1;
                    w_nxt = (vec_len == '0) ? DONE : READ;
                end
            end
            READ: begin
                stall   = 1'b1;
                mem1_re = (r_rd_bank == BANK1);
                mem2_re = (r_rd_bank == BANK2);
                rd_addr = w_rd_addr;
                w_nxt   = WRITE;
            end
            WRITE: begin
                // Read data from the previous READ cycle arrives now.
                stall       = 1'b1;
                alu_operand = (r_rd_bank == BANK1) ? rd_data_1 : rd_data_2;
                mem2_we     = (r_wr_bank == BANK2);
                mem3_we     = (r_wr_bank == BANK3);
                wr_addr     = w_wr_addr;
                wr_data     = alu_result;
                w_inc       = 1'b1;
                w_nxt       = w_last ? DONE : READ;
            end
            DONE: begin
                stall = 1'b1;
                done  = 1'b1;
                w_nxt = IDLE;
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    vec_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_base_i  (r_base_i),
        .i_base_j  (r_base_j),
        .i_len     (r_len),
        .o_rd_addr (w_rd_addr),
        .o_wr_addr (w_wr_addr),
        .o_last    (w_last)
    );

`ifdef VEC_MEM_SEQUENCER_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (w_inc && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_elems = r_perf;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: directed vector ops,
// expected bank traffic queued at issue, checked by a negedge monitor.
module tb_vec_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        vec_alu_op;
    logic        r_mem_1, r_mem_2, w_mem_2, w_mem_3;
    logic [7:0]  base_i, base_j, vec_len;
    logic [31:0] rd_data_1, rd_data_2;
    logic        alu_op_q;
    logic [31:0] alu_operand, alu_result;
    logic        mem1_re, mem2_re, mem2_we, mem3_we;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        stall, done;
`ifdef VEC_MEM_SEQUENCER_PERF_EN
    logic [31:0] perf_elems;
`endif

    vec_mem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_valid  (ctrl_valid),
        .ctrl_ready  (ctrl_ready),
        .vec_alu_op  (vec_alu_op),
        .r_mem_1     (r_mem_1),
        .r_mem_2     (r_mem_2),
        .w_mem_2     (w_mem_2),
        .w_mem_3     (w_mem_3),
        .base_i      (base_i),
        .base_j      (base_j),
        .vec_len     (vec_len),
        .rd_data_1   (rd_data_1),
        .rd_data_2   (rd_data_2),
        .alu_op_q    (alu_op_q),
        .alu_operand (alu_operand),
        .alu_result  (alu_result),
        .mem1_re     (mem1_re),
        .mem2_re     (mem2_re),
        .mem2_we     (mem2_we),
        .mem3_we     (mem3_we),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .stall       (stall),
        .done        (done)
`ifdef VEC_MEM_SEQUENCER_PERF_EN
        ,
        .perf_elems  (perf_elems)
`endif
    );

    always #5 clk = ~clk;

    // Environment: three banks with 1-cycle read latency, stub ALU.
    logic [31:0] bank1 [256];
    logic [31:0] bank2 [256];
    logic [31:0] bank3 [256];

    always @(posedge clk) begin
        if (mem1_re) rd_data_1 <= bank1[rd_addr];
        if (mem2_re) rd_data_2 <= bank2[rd_addr];
        if (mem2_we) bank2[wr_addr] <= wr_data;
        if (mem3_we) bank3[wr_addr] <= wr_data;
    end

    // mul: x*2, sum: x+1
    assign alu_result = alu_op_q ? (alu_operand << 1) : (alu_operand + 32'd1);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  bank;
        logic [7:0]  addr;
        logic [31:0] data;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    task automatic push(input logic [1:0] kind, input logic [1:0] bank,
                        input logic [7:0] addr, input logic [31:0] data,
                        input int at);
        ev_t e;
        e.kind = kind;
        e.bank = bank;
        e.addr = addr;
        e.data = data;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Element k of an op accepted at cycle c: read at c+1+2k, write c+2+2k.
    task automatic push_elem(input int c, input int k,
                             input logic [1:0] rb, input logic [1:0] wb,
                             input logic [7:0] bi, input logic [7:0] bj,
                             input logic [31:0] d);
        push(2'd0, rb, 8'(bi + k), 32'd0, c + 1 + 2*k);
        push(2'd1, wb, 8'(bj + k), d,     c + 2 + 2*k);
    endtask

    task automatic check_ev(input logic [1:0] kind, input logic [1:0] bank,
                            input logic [7:0] addr, input logic [31:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event kind=%0d bank=%0d addr=%h data=%h cyc=%0d",
                     kind, bank, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.bank !== bank || e.addr !== addr ||
                e.data !== data || e.at != cyc || stall !== 1'b1 ||
                ctrl_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL event got k%0d b%0d a%h d%h t%0d stall%b rdy%b exp k%0d b%0d a%h d%h t%0d stall1 rdy0",
                         kind, bank, addr, data, cyc, stall, ctrl_ready,
                         e.kind, e.bank, e.addr, e.data, e.at);
            end
        end
    endtask

    always @(negedge clk) begin : mon
        int ne;
        if (cyc > 2) begin
            ne = int'(mem1_re) + int'(mem2_re) + int'(mem2_we) + int'(mem3_we);
            if (ne > 0) begin
                n_checks++;
                if (ne > 1) begin
                    n_fail++;
                    $display("FAIL excl enables=%0d required<=1 cyc=%0d", ne, cyc);
                end
            end
            if (mem1_re === 1'b1) check_ev(2'd0, 2'd1, rd_addr, 32'd0);
            if (mem2_re === 1'b1) check_ev(2'd0, 2'd2, rd_addr, 32'd0);
            if (mem2_we === 1'b1) check_ev(2'd1, 2'd2, wr_addr, wr_data);
            if (mem3_we === 1'b1) check_ev(2'd1, 2'd3, wr_addr, wr_data);
            if (done === 1'b1)    check_ev(2'd2, 2'd0, 8'd0, 32'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {26'd0, ctrl_ready, stall, done, mem1_re, mem2_re,
                   mem2_we | mem3_we}, 32'h20);
    endtask

    task automatic drive(input logic op, input logic r1, input logic r2,
                         input logic w2, input logic w3,
                         input logic [7:0] bi, input logic [7:0] bj,
                         input logic [7:0] n, output int c);
        @(negedge clk);
        vec_alu_op = op;
        r_mem_1    = r1;
        r_mem_2    = r2;
        w_mem_2    = w2;
        w_mem_3    = w3;
        base_i     = bi;
        base_j     = bj;
        vec_len    = n;
        ctrl_valid = 1'b1;
        c          = cyc;
    endtask

    task automatic release_in();
        @(negedge clk);
        ctrl_valid = 1'b0;
        r_mem_1    = 1'b0;
        r_mem_2    = 1'b0;
        w_mem_2    = 1'b0;
        w_mem_3    = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, exp_q.size(), 32'd0);
        @(negedge clk);
        chk_idle({name, "_idle"});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        rst        = 1'b1;
        ctrl_valid = 1'b0;
        vec_alu_op = 1'b0;
        r_mem_1    = 1'b0;
        r_mem_2    = 1'b0;
        w_mem_2    = 1'b0;
        w_mem_3    = 1'b0;
        base_i     = '0;
        base_j     = '0;
        vec_len    = '0;
        for (int i = 0; i < 256; i++) begin
            bank1[i] = 32'd0;
            bank2[i] = 32'd0;
            bank3[i] = 32'd0;
        end
        for (int i = 0; i < 8; i++) bank1[8'h10 + i] = 32'(i + 1);
        bank1[8'hFE] = 32'd7;
        bank1[8'hFF] = 32'd8;
        bank1[8'h00] = 32'd9;
        bank1[8'h40] = 32'd11;
        bank2[8'h40] = 32'd100;
        bank2[8'h30] = 32'd5;
        bank2[8'h50] = 32'd10;
        bank2[8'h51] = 32'd20;

        repeat (3) @(negedge clk);
        chk_idle("reset_ctrl");
        chk("reset_opq_wdata", {alu_op_q, wr_data[30:0]}, 32'd0);
        chk("reset_addr", {rd_addr, wr_addr}, 32'd0);
`ifdef VEC_MEM_SEQUENCER_PERF_EN
        chk("perf_reset", perf_elems, 32'd0);
`endif
        rst = 1'b0;

        // MULFV N=4: bank1[10..13]={1,2,3,4} -> bank2[20..23]={2,4,6,8}
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 8'd4, c);
        push_elem(c, 0, 2'd1, 2'd2, 8'h10, 8'h20, 32'd2);
        push_elem(c, 1, 2'd1, 2'd2, 8'h10, 8'h20, 32'd4);
        push_elem(c, 2, 2'd1, 2'd2, 8'h10, 8'h20, 32'd6);
        push_elem(c, 3, 2'd1, 2'd2, 8'h10, 8'h20, 32'd8);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 9);
        release_in();
        wait_drain("mulfv", 20);

        // Wrap: rd FE,FF,00 -> wr FF,00,01 with {14,16,18}
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE, 8'hFF, 8'd3, c);
        push_elem(c, 0, 2'd1, 2'd2, 8'hFE, 8'hFF, 32'd14);
        push_elem(c, 1, 2'd1, 2'd2, 8'hFE, 8'hFF, 32'd16);
        push_elem(c, 2, 2'd1, 2'd2, 8'hFE, 8'hFF, 32'd18);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 7);
        release_in();
        wait_drain("wrap", 20);
`ifdef VEC_MEM_SEQUENCER_PERF_EN
        chk("perf_after_7", perf_elems, 32'd7);
`endif

        // SUMFV N=1: bank2[30]=5 -> bank3[40]=6, done at +3
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 8'h40, 8'd1, c);
        push_elem(c, 0, 2'd2, 2'd3, 8'h30, 8'h40, 32'd6);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 3);
        release_in();
        wait_drain("sumfv", 10);
        chk("sumfv_bank3", bank3[8'h40], 32'd6);

        // INCRI-style bundle: no enables, dropped
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02, 8'd5, c);
        release_in();
        chk_idle("noop_c1");
        @(negedge clk);
        chk_idle("noop_c2");

        // N=0 MULFV: only a done pulse one cycle later
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 8'd0, c);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 1);
        release_in();
        wait_drain("n0", 6);

        // Both read/write enables: bank1 and bank2 win
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h70, 8'd1, c);
        push_elem(c, 0, 2'd1, 2'd2, 8'h40, 8'h70, 32'd22);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 3);
        release_in();
        wait_drain("prio", 10);

        // Bank 2 as source and destination, sum op
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h50, 8'h60, 8'd2, c);
        push_elem(c, 0, 2'd2, 2'd2, 8'h50, 8'h60, 32'd11);
        push_elem(c, 1, 2'd2, 2'd2, 8'h50, 8'h60, 32'd21);
        push(2'd2, 2'd0, 8'd0, 32'd0, c + 5);
        release_in();
        wait_drain("b2b2", 12);

        // Reset during the 3rd WRITE of an N=8 op
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 8'h80, 8'd8, c);
        push_elem(c, 0, 2'd1, 2'd2, 8'h10, 8'h80, 32'd2);
        push_elem(c, 1, 2'd1, 2'd2, 8'h10, 8'h80, 32'd4);
        push_elem(c, 2, 2'd1, 2'd2, 8'h10, 8'h80, 32'd6);
        release_in();
        while (cyc < c + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rstmid_idle");
        chk("rstmid_pending", exp_q.size(), 32'd0);
`ifdef VEC_MEM_SEQUENCER_PERF_EN
        chk("perf_cleared", perf_elems, 32'd0);
`endif
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk_idle("rstmid_after");
        chk("rstmid_bank2_82", bank2[8'h82], 32'd6);
        chk("rstmid_bank2_83", bank2[8'h83], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
